cnn_stream_sequencer: RTL
=========================

Name: cnn_stream_sequencer

Overview:
- Front-end controller for the CNN datapath. Sits between the single 8-bit byte stream (`data_in` / `mode`) and the conv-kernel store, FC-weight store and image line buffers.
- In config mode it counts weight bytes and issues write strobes and addresses: first the 3x3x3 conv kernel, then the FC weights.
- In data mode it tracks raster row/col of image pixels, flags complete 3x3 windows for the conv engine, and marks frame end.

Parameters:
- DW, 8, data byte width (signed)
- CONV_NUM, 27, number of conv kernel weights
- FC_NUM, 27, number of FC weights
- AW, 5, weight address width (must satisfy 2^AW >= max(CONV_NUM, FC_NUM))
- IMG_H, 11, image rows
- IMG_W, 12, image columns
- K, 3, conv window size
- PW, 4, row/col index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  1  0 = weight load, 1 = image stream
- in_valid  in  1  data_in holds a byte
- data_in  in  DW  signed input byte
- in_ready  out  1  sequencer accepts a byte this cycle
- conv_we  out  1  write strobe, conv kernel store
- fc_we  out  1  write strobe, FC weight store
- wt_addr  out  AW  weight address (restarts at 0 for FC)
- wt_data  out  DW  registered weight byte
- pix_we  out  1  write strobe, line buffer
- pix_row  out  PW  row of current pixel
- pix_col  out  PW  column of current pixel
- pix_data  out  DW  registered pixel byte
- win_valid  out  1  current pixel completes a KxK window
- load_done  out  1  level; all weights written
- frame_done  out  1  one-cycle pulse; last pixel of frame
- seq_err  out  1  sticky; illegal mode change

Behaviour:
- Reset (rst=0, async): state IDLE. Every output and every counter is 0; `seq_err` is cleared.
- Transfer occurs when `in_valid && in_ready`. All outputs are registered, so strobes, address, data, row/col and flags appear 1 cycle after the accepted byte.
- IDLE: `in_ready`=0. The next cycle goes to LOAD_CONV if `mode`=0, else STREAM. The weight counter and row/col are cleared.
- LOAD_CONV: `in_ready`=1.
  - Each transfer gives `conv_we`=1, `wt_addr`=count, `wt_data`=byte.
  - The transfer at count CONV_NUM-1 resets the count to 0 and moves to LOAD_FC.
- LOAD_FC: same as LOAD_CONV but with `fc_we`. The transfer at count FC_NUM-1 moves to LOADED.
  - `load_done`=1 from the cycle after that last `fc_we`, held until reset or re-entry to LOAD_CONV.
- LOADED: `in_ready`=0 and bytes are ignored. `mode`=1 moves to STREAM next cycle; this is legal and sets no error.
- STREAM: `in_ready`=1.
  - Each transfer gives `pix_we`=1 with `pix_row`/`pix_col`/`pix_data`. Column increments; at IMG_W-1 it wraps to 0 and the row increments.
  - `win_valid`=`pix_we` && row>=K-1 && col>=K-1, giving (IMG_H-K+1)*(IMG_W-K+1) windows per frame (90 by default).
  - `frame_done` pulses together with `pix_we` of pixel (IMG_H-1, IMG_W-1). Row/col return to 0 and STREAM continues, so back-to-back frames need no idle gap.
- Mode change rules:
  - `mode` 1->0 in STREAM with row=col=0 (frame boundary) is legal: go to IDLE and reload weights.
  - `mode` change in LOAD_CONV, LOAD_FC, or in STREAM mid-frame sets `seq_err`=1 (sticky until reset), drops the in-flight byte, and goes to IDLE. Counters are cleared; `load_done` is cleared when restarting in LOAD_CONV.
- `mode` change and a transfer in the same cycle: the mode change wins and the byte is not written.
- Reset mid-operation: immediate abort. No strobe is emitted after `rst` falls.
- `in_valid`=0 stalls all counters; strobes stay 0 during stall cycles.

Test Plan:
- Load: reset, mode=0, 54 bytes with `in_valid`=1 continuously (first 27 = i+j+k pattern, next 27 = 1..27) -> 27 `conv_we` at addr 0..26, then 27 `fc_we` at addr 0..26 with `wt_data` 1..27. `load_done` rises 1 cycle after the last `fc_we`; the 55th byte is not accepted.
- Stream: after load, mode=1, 132 pixels (value i+j+1) -> 132 `pix_we`, rows 0..10 / cols 0..11. `win_valid` first on (2,2) and 90 times in total. Single `frame_done` on (10,11). A 133rd pixel is written at (0,0).
- Stall: toggle `in_valid` every other cycle during load -> still exactly 27+27 strobes, addresses contiguous, no strobe on idle cycles.
- Mid-frame mode error: mode 1->0 after 20 pixels -> `seq_err`=1, next pixel not written, IDLE then LOAD_CONV. `seq_err` remains 1 until `rst` is pulsed low.
- Async reset: `rst`=0 mid LOAD_FC at addr 10 -> all outputs 0 immediately. After release with mode=0, loading restarts with `conv_we` at addr 0.

Source files
------------

// File: rtl/cnn_stream_sequencer_if.sv
// Byte-stream and store-side signal bundle for the CNN stream sequencer.
// Latency: none, wiring only.
// Backpressure: in_ready from the sequencer gates in_valid/data_in from the source.
// Ports: master = byte source (drives mode/in_valid/data_in, observes everything else);
//        slave  = sequencer (observes the byte stream, drives strobes, addresses, data and status).
interface cnn_stream_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 5,
  parameter int PW = 4
);
  logic                 mode;
  logic                 in_valid;
  logic signed [DW-1:0] data_in;
  logic                 in_ready;
  logic                 conv_we;
  logic                 fc_we;
  logic [AW-1:0]        wt_addr;
  logic signed [DW-1:0] wt_data;
  logic                 pix_we;
  logic [PW-1:0]        pix_row;
  logic [PW-1:0]        pix_col;
  logic signed [DW-1:0] pix_data;
  logic                 win_valid;
  logic                 load_done;
  logic                 frame_done;
  logic                 seq_err;

  modport master (
    output mode, in_valid, data_in,
    input  in_ready, conv_we, fc_we, wt_addr, wt_data, pix_we, pix_row, pix_col,
           pix_data, win_valid, load_done, frame_done, seq_err
  );

  modport slave (
    input  mode, in_valid, data_in,
    output in_ready, conv_we, fc_we, wt_addr, wt_data, pix_we, pix_row, pix_col,
           pix_data, win_valid, load_done, frame_done, seq_err
  );
endinterface

// File: rtl/cnn_stream_sequencer.sv
// Front-end controller: steers the byte stream into conv/FC weight stores and image line buffers.
// Latency: strobes, address, data, row/col and flags are registered, one cycle after the accepted byte.
// Backpressure: in_ready is low in IDLE and LOADED; in_valid low stalls all counters.
// Ports: clk (rising edge), rst (async active-low), bus (slave modport): mode/in_valid/data_in in;
//        in_ready, conv_we/fc_we/wt_addr/wt_data, pix_we/pix_row/pix_col/pix_data,
//        win_valid, load_done, frame_done, seq_err out.
module cnn_stream_sequencer #(
  parameter int DW       = 8,
  parameter int CONV_NUM = 27,
  parameter int FC_NUM   = 27,
  parameter int AW       = 5,
  parameter int IMG_H    = 11,
  parameter int IMG_W    = 12,
  parameter int K        = 3,
  parameter int PW       = 4
) (
  input logic                   clk,
  input logic                   rst,
  cnn_stream_sequencer_if.slave bus
);

  localparam logic [AW-1:0] CONV_LAST = AW'(CONV_NUM - 1);
  localparam logic [AW-1:0] FC_LAST   = AW'(FC_NUM - 1);
  localparam logic [PW-1:0] ROW_LAST  = PW'(IMG_H - 1);
  localparam logic [PW-1:0] COL_LAST  = PW'(IMG_W - 1);
  localparam logic [PW-1:0] WIN_MIN   = PW'(K - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CONV,
    S_LOAD_FC,
    S_LOADED,
    S_STREAM
  } state_t;

  state_t               r_state;
  logic [AW-1:0]        r_cnt;
  logic [PW-1:0]        r_row;
  logic [PW-1:0]        r_col;
  logic                 r_in_ready;
  logic                 r_conv_we;
  logic                 r_fc_we;
  logic [AW-1:0]        r_wt_addr;
  logic signed [DW-1:0] r_wt_data;
  logic                 r_pix_we;
  logic [PW-1:0]        r_pix_row;
  logic [PW-1:0]        r_pix_col;
  logic signed [DW-1:0] r_pix_data;
  logic                 r_win_valid;
  logic                 r_load_done;
  logic                 r_frame_done;
  logic                 r_seq_err;

  logic w_xfer;
  assign w_xfer = bus.in_valid && r_in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_in_ready   <= 1'b0;
      r_conv_we    <= 1'b0;
      r_fc_we      <= 1'b0;
      r_wt_addr    <= '0;
      r_wt_data    <= '0;
      r_pix_we     <= 1'b0;
      r_pix_row    <= '0;
      r_pix_col    <= '0;
      r_pix_data   <= '0;
      r_win_valid  <= 1'b0;
      r_load_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_seq_err    <= 1'b0;
    end else begin
      // Strobes and pulses are single-cycle unless re-armed by a transfer below.
      r_conv_we    <= 1'b0;
      r_fc_we      <= 1'b0;
      r_pix_we     <= 1'b0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt      <= '0;
          r_row      <= '0;
          r_col      <= '0;
          r_in_ready <= 1'b1;
          if (!bus.mode) begin
            r_state     <= S_LOAD_CONV;
            r_load_done <= 1'b0;
          end else begin
            r_state <= S_STREAM;
          end
        end

        S_LOAD_CONV, S_LOAD_FC: begin
          if (bus.mode) begin
            // Mode flip mid-load: the in-flight byte is dropped.
            r_seq_err  <= 1'b1;
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_cnt      <= '0;
          end else if (w_xfer) begin
            r_wt_addr <= r_cnt;
            r_wt_data <= bus.data_in;
            if (r_state == S_LOAD_CONV) begin
              r_conv_we <= 1'b1;
              if (r_cnt == CONV_LAST) begin
                r_cnt   <= '0;
                r_state <= S_LOAD_FC;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else begin
              r_fc_we <= 1'b1;
              if (r_cnt == FC_LAST) begin
                r_cnt      <= '0;
                r_state    <= S_LOADED;
                r_in_ready <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
        end

        S_LOADED: begin
          // Entered on the edge that raised the last fc_we, so load_done trails it by a cycle.
          r_load_done <= 1'b1;
          if (bus.mode) begin
            r_state    <= S_STREAM;
            r_in_ready <= 1'b1;
          end
        end

        S_STREAM: begin
          if (!bus.mode) begin
            // Leaving on a frame boundary is a clean weight reload; mid-frame it is an error.
            if (r_row != '0 || r_col != '0) begin
              r_seq_err <= 1'b1;
            end
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
          end else if (w_xfer) begin
            r_pix_we     <= 1'b1;
            r_pix_row    <= r_row;
            r_pix_col    <= r_col;
            r_pix_data   <= bus.data_in;
            r_win_valid  <= (r_row >= WIN_MIN) && (r_col >= WIN_MIN);
            r_frame_done <= (r_row == ROW_LAST) && (r_col == COL_LAST);
            if (r_col == COL_LAST) begin
              r_col <= '0;
              r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.conv_we    = r_conv_we;
  assign bus.fc_we      = r_fc_we;
  assign bus.wt_addr    = r_wt_addr;
  assign bus.wt_data    = r_wt_data;
  assign bus.pix_we     = r_pix_we;
  assign bus.pix_row    = r_pix_row;
  assign bus.pix_col    = r_pix_col;
  assign bus.pix_data   = r_pix_data;
  assign bus.win_valid  = r_win_valid;
  assign bus.load_done  = r_load_done;
  assign bus.frame_done = r_frame_done;
  assign bus.seq_err    = r_seq_err;

endmodule
